// File: rtl/mult32_seq_karatsuba.sv
// Sequential 32x32 multiplier: four 16x16 partial products through one karatsuba_16, shift-accumulated.
// Optional macro MULT32_SEQ_SIGNED_EN selects two's complement operands and product.
`timescale 1ns/1ps

module karatsuba_16 (
  input  logic [15:0] X,
  input  logic [15:0] Y,
  output logic [31:0] Z
);
  logic [7:0]  xl, xh, yl, yh;
  logic [8:0]  xs, ys;
  logic [15:0] z0, z2;
  logic [17:0] zm, z1;

  assign xl = X[7:0];
  assign xh = X[15:8];
  assign yl = Y[7:0];
  assign yh = Y[15:8];
  assign xs = 9'(xh) + 9'(xl);
  assign ys = 9'(yh) + 9'(yl);
  assign z0 = 16'(xl) * 16'(yl);
  assign z2 = 16'(xh) * 16'(yh);
  assign zm = 18'(xs) * 18'(ys);
  // Middle term recovered from the sum product; never negative.
  assign z1 = zm - 18'(z0) - 18'(z2);
  assign Z  = (32'(z2) << 16) + (32'(z1) << 8) + 32'(z0);
endmodule

module mult32_seq_karatsuba (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] p
);
  localparam int unsigned HALF = 16;
  localparam int unsigned W    = 2 * HALF;
  localparam int unsigned PW   = 4 * HALF;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P1   = 3'd2;
  localparam logic [2:0] S_P2   = 3'd3;
  localparam logic [2:0] S_P3   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d, p_q, p_d;
  logic            done_q, done_d, busy_q, busy_d;
  logic [HALF-1:0] kx, ky;
  logic [W-1:0]    kz;
`ifdef MULT32_SEQ_SIGNED_EN
  logic            sign_q, sign_d;
`endif

  karatsuba_16 u_core (.X(kx), .Y(ky), .Z(kz));

  // Half-pair selection; zero outside P0..P3 so the core stays quiet.
  always_comb begin
    kx = '0;
    ky = '0;
    case (state_q)
      S_P0:    begin kx = a_q[HALF-1:0]; ky = b_q[HALF-1:0]; end
      S_P1:    begin kx = a_q[HALF-1:0]; ky = b_q[W-1:HALF]; end
      S_P2:    begin kx = a_q[W-1:HALF]; ky = b_q[HALF-1:0]; end
      S_P3:    begin kx = a_q[W-1:HALF]; ky = b_q[W-1:HALF]; end
      default: begin kx = '0; ky = '0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
`ifdef MULT32_SEQ_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_P0;
          acc_d   = '0;
`ifdef MULT32_SEQ_SIGNED_EN
          a_d     = a[W-1] ? W'(0) - a : a;
          b_d     = b[W-1] ? W'(0) - b : b;
          sign_d  = a[W-1] ^ b[W-1];
`else
          a_d     = a;
          b_d     = b;
`endif
        end
      end
      S_P0: begin
        acc_d   = acc_q + PW'(kz);
        state_d = S_P1;
      end
      S_P1: begin
        acc_d   = acc_q + (PW'(kz) << HALF);
        state_d = S_P2;
      end
      S_P2: begin
        acc_d   = acc_q + (PW'(kz) << HALF);
        state_d = S_P3;
      end
      S_P3: begin
        acc_d   = acc_q + (PW'(kz) << W);
        state_d = S_DONE;
`ifdef MULT32_SEQ_SIGNED_EN
        p_d     = sign_q ? PW'(0) - acc_d : acc_d;
`else
        p_d     = acc_d;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MULT32_SEQ_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef MULT32_SEQ_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;
endmodule

// File: doc/mult32_seq_karatsuba.md
Name: mult32_seq_karatsuba

Overview:
- Sequential 32x32 unsigned multiplier built on one instance of the existing combinational karatsuba_16 core.
- Splits each operand into 16-bit halves, feeds one half-pair per cycle into karatsuba_16, and shift-accumulates the four partial products.
- Sits directly upstream and downstream of karatsuba_16: it drives X/Y and consumes Z.
- Gives the datapath a 64-bit product with a start/done handshake.

Parameters:
- HALF, 16, operand half width; fixed by karatsuba_16. Full operand width is 2*HALF and product width is 4*HALF.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  32  multiplicand; latched on the accepted start.
- b  input  32  multiplier; latched on the accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  single-cycle pulse; p is valid and new in this cycle.
- p  output  64  product; holds its value until the next done.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, accumulator=0, operand regs=0, p=0, done=0, busy=0.
  - Reset takes priority over every other event, including mid-operation.
  - An aborted operation never raises done.
- States: IDLE -> P0 -> P1 -> P2 -> P3 -> DONE -> IDLE.
- IDLE: when start=1 at edge T, latch a/b, clear the accumulator, go to P0. start=0 stays in IDLE.
- P0..P3 occupy edges T+1..T+4. Each cycle drives karatsuba_16 combinationally, and Z is added at the edge.
  - P0: a[15:0] * b[15:0], added shifted by 0.
  - P1: a[15:0] * b[31:16], added shifted by 16.
  - P2: a[31:16] * b[15:0], added shifted by 16.
  - P3: a[31:16] * b[31:16], added shifted by 32.
- Accumulator is 64 bits. No overflow is possible because the true product is at most 2^64 - 2^33 + 1.
- DONE: the cycle after edge T+4. done=1 and p equals the accumulator, registered at the transition into DONE. Next edge returns to IDLE.
- Latency: start sampled at edge T, done high in cycle T+5, and the next start is accepted at the edge after DONE. Throughput is one product per 6 cycles.
- start while busy (P0..DONE) is ignored. Latched operands are unaffected; changes on a/b after acceptance have no effect.
- start held high continuously: a new operation begins from every IDLE cycle.
- The karatsuba_16 inputs are driven to 0 in IDLE and DONE, so the multiplier does not toggle when idle.
- p changes only on entry to DONE or on reset.

Optional Feature:
- Macro: MULT32_SEQ_SIGNED_EN.
- Defined: a, b and p are two's complement.
  - On accept, store |a| and |b| and a sign flag = a[31]^b[31].
  - On entry to DONE, p = sign ? -acc : acc.
  - -2^31 has magnitude 0x8000_0000 and is handled correctly.
  - Latency is unchanged.
- Not defined: purely unsigned. No sign logic or sign register is present.

Test Plan:
- Reset then a=0xFFFF_FFFF, b=0xFFFF_FFFF, start for 1 cycle -> busy during cycles T+1..T+5; done only at T+5 with p=0xFFFF_FFFE_0000_0001; busy=0 at T+6.
- a=65535, b=65537 (exercises the cross terms) -> p=0x0000_0000_FFFF_FFFF. Then a=0x0001_0000, b=0x0001_0000 -> p=0x0000_0001_0000_0000.
- Accept a=3, b=5, then pulse start with a=7, b=7 at T+2, and toggle a/b randomly until done -> p=15, exactly one done; the second start is ignored.
- Accept a=0xFFFF_FFFF, b=2, assert rst at T+3 -> done never pulses, p=0, busy=0 the cycle after reset.
  - Then a=0, b=0x1234_5678 -> p=0.
- start held high with operands fixed at a=10, b=20 -> done every 6 cycles, p=200 each time, p stable between pulses.
- With MULT32_SEQ_SIGNED_EN:
  - a=0xFFFF_FFFE (-2), b=3 -> p=0xFFFF_FFFF_FFFF_FFFA.
  - a=b=0x8000_0000 -> p=0x4000_0000_0000_0000.
  - Plus 10000 random pairs checked against $signed(a)*$signed(b); without the macro, checked against the unsigned a*b.
